// File: rtl/ahb_mem_slave_p.sv
// AHB-Lite memory slave with byte-lane writes, programmable wait states and
// two-cycle ERROR responses.
//
// Ports:
//   hclk, hreset_n         clock, asynchronous active-low reset
//   hsel, haddr, htrans,   AHB address phase
//   hwrite, hsize,
//   hburst, hprot          (hburst/hprot are accepted and ignored)
//   hwdata                 write data, valid in the data phase
//   hready                 bus ready, high ends the previous data phase
//   wait_cfg               wait states, sampled when a transfer is accepted
//   hrdata                 read data (zero during ERROR responses)
//   hreadyout, hresp       slave ready and response (1 = ERROR)
module ahb_mem_slave_p #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MEM_BYTES = 4096,
  parameter int unsigned MAX_WS    = 15
) (
  input  logic              hclk,
  input  logic              hreset_n,
  input  logic              hsel,
  input  logic [31:0]       haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [2:0]        hburst,
  input  logic [3:0]        hprot,
  input  logic [DATA_W-1:0] hwdata,
  input  logic              hready,
  input  logic [3:0]        wait_cfg,
  output logic [DATA_W-1:0] hrdata,
  output logic              hreadyout,
  output logic              hresp
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned LB    = $clog2(NB);
  localparam int unsigned WORDS = MEM_BYTES / NB;
  localparam int unsigned WW    = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {StIdle, StWait, StErr1, StErr2} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              dp_valid_q, dp_valid_d;
  logic              dp_write_q, dp_write_d;
  logic [WW-1:0]     dp_widx_q, dp_widx_d;
  logic [NB-1:0]     dp_be_q, dp_be_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [DATA_W-1:0] mem [WORDS];

  logic              ready_int;
  logic [31:0]       offset, size_bytes, align_mask, lane;
  logic              xfer_err, accept, accept_ok, wr_en;
  logic [WW-1:0]     widx;
  logic [NB-1:0]     be;
  logic [3:0]        ws;
  logic [DATA_W-1:0] fwd_word;

  logic unused_ok;
  assign unused_ok = ^{hburst, hprot, htrans[0]};

  // New address phases are only taken while our own data phase can end.
  assign ready_int = (state_q == StIdle) || (state_q == StErr2);
  assign accept    = hsel & hready & htrans[1] & ready_int;
  assign accept_ok = accept & ~xfer_err;
  // A pending OKAY data phase completes whenever we are back in StIdle.
  assign wr_en     = (state_q == StIdle) && dp_valid_q && dp_write_q;

  // Address-phase decode
  always_comb begin
    offset     = haddr & 32'(MEM_BYTES - 1);
    size_bytes = 32'd1 << hsize;
    align_mask = size_bytes - 32'd1;
    lane       = offset & 32'(NB - 1);
    xfer_err   = (haddr >= 32'(MEM_BYTES)) || (size_bytes > 32'(NB)) ||
                 ((haddr & align_mask) != 32'd0);
    widx       = WW'(offset >> LB);
    be         = '0;
    for (int i = 0; i < int'(NB); i++) begin
      be[i] = (32'(i) >= lane) && (32'(i) < lane + size_bytes);
    end
    ws = (32'(wait_cfg) > MAX_WS) ? 4'(MAX_WS) : wait_cfg;
  end

  // Read word with bytes of a write completing on this same edge forwarded in.
  always_comb begin
    fwd_word = mem[widx];
    for (int i = 0; i < int'(NB); i++) begin
      if (wr_en && (dp_widx_q == widx) && dp_be_q[i]) begin
        fwd_word[8*i +: 8] = hwdata[8*i +: 8];
      end
    end
  end

  // Memory array, deliberately without reset.
  always_ff @(posedge hclk) begin
    if (wr_en) begin
      for (int i = 0; i < int'(NB); i++) begin
        if (dp_be_q[i]) mem[dp_widx_q][8*i +: 8] <= hwdata[8*i +: 8];
      end
    end
  end

  // Data-phase bookkeeping
  always_comb begin
    cnt_d      = cnt_q;
    dp_valid_d = dp_valid_q;
    dp_write_d = dp_write_q;
    dp_widx_d  = dp_widx_q;
    dp_be_d    = dp_be_q;
    rdata_d    = rdata_q;
    if (accept_ok) begin
      cnt_d = ws;
    end else if (state_q == StWait) begin
      cnt_d = cnt_q - 4'd1;
    end
    if (ready_int) begin
      dp_valid_d = accept_ok;
      dp_write_d = hwrite;
      dp_widx_d  = widx;
      dp_be_d    = be;
    end
    // Read data is captured at accept; nothing else can write until it is consumed.
    if (accept) begin
      rdata_d = xfer_err ? '0 : fwd_word;
    end
  end

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      cnt_q      <= 4'd0;
      dp_valid_q <= 1'b0;
      dp_write_q <= 1'b0;
      dp_widx_q  <= '0;
      dp_be_q    <= '0;
      rdata_q    <= '0;
    end else begin
      cnt_q      <= cnt_d;
      dp_valid_q <= dp_valid_d;
      dp_write_q <= dp_write_d;
      dp_widx_q  <= dp_widx_d;
      dp_be_q    <= dp_be_d;
      rdata_q    <= rdata_d;
    end
  end

  // FSM state register
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StErr2: begin
        state_d = StIdle;
        if (accept) begin
          if (xfer_err)        state_d = StErr1;
          else if (ws != 4'd0) state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q == 4'd1) state_d = StIdle;
      end
      StErr1: state_d = StErr2;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    hreadyout = 1'b1;
    hresp     = 1'b0;
    hrdata    = rdata_q;
    unique case (state_q)
      StIdle: ;
      StWait: hreadyout = 1'b0;
      StErr1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
        hrdata    = '0;
      end
      StErr2: begin
        hresp  = 1'b1;
        hrdata = '0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ahb_mem_slave_p.sv
// Bench for ahb_mem_slave_p: a 32-bit and a 64-bit instance share one AHB bus,
// each selected by its own hsel. A transfer-level model tracks expected
// hreadyout/hresp/hrdata and the byte contents of both memories.
module tb_ahb_mem_slave_p;

  localparam int MemBytes = 4096;

  typedef struct {
    bit          sel;
    bit          tgt;      // 0: 32-bit slave, 1: 64-bit slave
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [1:0]  trans;
    logic [63:0] val;      // byte k of val goes to addr + k
    logic [3:0]  ws;
    bit          chk;
    logic [63:0] chk_val;
  } xfer_t;

  logic        hclk = 1'b0;
  logic        hreset_n;
  logic        hsel32, hsel64;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot, wait_cfg;
  logic [63:0] hwdata;
  logic        hready;
  logic [31:0] hrdata32;
  logic [63:0] hrdata64;
  logic        hreadyout32, hresp32, hreadyout64, hresp64;

  always #5 hclk = ~hclk;

  ahb_mem_slave_p #(.DATA_W(32), .MEM_BYTES(MemBytes), .MAX_WS(15)) u_dut32 (
    .hclk(hclk), .hreset_n(hreset_n), .hsel(hsel32), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hwdata(hwdata[31:0]),
    .hready(hready), .wait_cfg(wait_cfg), .hrdata(hrdata32), .hreadyout(hreadyout32),
    .hresp(hresp32)
  );

  ahb_mem_slave_p #(.DATA_W(64), .MEM_BYTES(MemBytes), .MAX_WS(15)) u_dut64 (
    .hclk(hclk), .hreset_n(hreset_n), .hsel(hsel64), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hwdata(hwdata),
    .hready(hready), .wait_cfg(wait_cfg), .hrdata(hrdata64), .hreadyout(hreadyout64),
    .hresp(hresp64)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, act, exp);
  endtask

  // Reference model
  logic [7:0] mem_m [2][MemBytes];
  xfer_t      q[$];
  xfer_t      dp;            // transfer currently in its data phase
  int         dp_kind;       // 0 none, 1 OKAY transfer, 2 ERROR response
  int         dp_left;       // wait cycles still to come
  bit         dp_err1;       // first ERROR cycle

  function automatic int nbytes(bit tgt);
    return tgt ? 8 : 4;
  endfunction

  function automatic bit is_err(xfer_t x);
    int sz = 1 << x.size;
    if (x.addr >= 32'(MemBytes)) return 1'b1;
    if (sz > nbytes(x.tgt)) return 1'b1;
    return (int'(x.addr) % sz) != 0;
  endfunction

  function automatic logic [63:0] model_word(bit tgt, logic [31:0] addr);
    logic [63:0] w = '0;
    int nb = nbytes(tgt);
    int base = int'(addr) - (int'(addr) % nb);
    for (int j = 0; j < nb; j++) w[8*j +: 8] = mem_m[tgt][base + j];
    return w;
  endfunction

  function automatic void model_write(xfer_t x);
    for (int k = 0; k < (1 << x.size); k++) mem_m[x.tgt][int'(x.addr) + k] = x.val[8*k +: 8];
  endfunction

  function automatic xfer_t idle_xfer();
    xfer_t x;
    x.sel = 1'b0; x.tgt = 1'b0; x.wr = 1'b0; x.addr = '0; x.size = '0; x.trans = 2'd0;
    x.val = '0; x.ws = '0; x.chk = 1'b0; x.chk_val = '0;
    return x;
  endfunction

  function automatic xfer_t mk(bit tgt, bit wr, logic [31:0] addr, logic [2:0] size,
                               logic [63:0] val, logic [3:0] ws);
    xfer_t x = idle_xfer();
    x.sel = 1'b1; x.tgt = tgt; x.wr = wr; x.addr = addr; x.size = size;
    x.trans = 2'd2; x.val = val; x.ws = ws;
    return x;
  endfunction

  function automatic xfer_t mk_rd_chk(bit tgt, logic [31:0] addr, logic [2:0] size,
                                      logic [3:0] ws, logic [63:0] exp);
    xfer_t x = mk(tgt, 1'b0, addr, size, 64'd0, ws);
    x.chk = 1'b1; x.chk_val = exp;
    return x;
  endfunction

  function automatic xfer_t rand_xfer();
    xfer_t x = idle_xfer();
    int sz;
    x.sel   = $urandom_range(0, 9) != 0;
    x.tgt   = 1'($urandom_range(0, 1));
    x.wr    = 1'($urandom_range(0, 1));
    x.trans = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
    x.size  = 3'($urandom_range(0, x.tgt ? 3 : 2));
    if ($urandom_range(0, 15) == 0) x.size = 3'($urandom_range(0, 7));
    sz = 1 << x.size;
    // Small window so reads often hit words just written
    x.addr = 32'($urandom_range(0, 63)) & ~32'(sz - 1);
    case ($urandom_range(0, 19))
      0: x.addr = 32'($urandom_range(0, 63));
      1: x.addr = 32'(MemBytes) + 32'($urandom_range(0, 255)) * 32'(sz);
      default: ;
    endcase
    x.val = {$urandom, $urandom};
    x.ws  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 6)) : 4'd0;
    return x;
  endfunction

  task automatic drive(input xfer_t x);
    hsel32   = x.sel && !x.tgt;
    hsel64   = x.sel && x.tgt;
    haddr    = x.addr;
    htrans   = x.trans;
    hwrite   = x.wr;
    hsize    = x.size;
    wait_cfg = x.ws;
    hburst   = 3'($urandom);
    hprot    = 4'($urandom);
  endtask

  // One bus cycle: check outputs at negedge, then present the next address phase.
  task automatic step();
    bit          rdy, rsp, on0, on1;
    xfer_t       nx;
    logic [63:0] act;
    @(negedge hclk);
    rdy = 1'b1;
    rsp = 1'b0;
    if (dp_kind == 1 && dp_left > 0) rdy = 1'b0;
    if (dp_kind == 2) begin
      rsp = 1'b1;
      rdy = !dp_err1;
    end
    on0 = (dp_kind != 0) && !dp.tgt;
    on1 = (dp_kind != 0) && dp.tgt;
    check_eq("hreadyout32", 64'(hreadyout32), on0 ? 64'(rdy) : 64'd1);
    check_eq("hresp32", 64'(hresp32), on0 ? 64'(rsp) : 64'd0);
    check_eq("hreadyout64", 64'(hreadyout64), on1 ? 64'(rdy) : 64'd1);
    check_eq("hresp64", 64'(hresp64), on1 ? 64'(rsp) : 64'd0);
    act = dp.tgt ? hrdata64 : 64'(hrdata32);
    if (dp_kind == 2) check_eq("err_hrdata", act, 64'd0);
    if (dp_kind == 1 && !dp.wr && rdy) begin
      check_eq("read_hrdata", act, model_word(dp.tgt, dp.addr));
      if (dp.chk) check_eq("directed_hrdata", act, dp.chk_val);
    end
    nx = idle_xfer();
    if (rdy) begin
      if (dp_kind == 1 && dp.wr) model_write(dp);
      if (q.size() > 0) nx = q.pop_front();
      drive(nx);
      hready = 1'b1;
    end else begin
      hready   = 1'b0;
      wait_cfg = 4'($urandom);  // must not disturb the running data phase
    end
    @(posedge hclk);
    #1;
    if (rdy) begin
      dp = nx;
      if (!nx.sel || !nx.trans[1]) begin
        dp_kind = 0;
      end else if (is_err(nx)) begin
        dp_kind = 2;
        dp_err1 = 1'b1;
      end else begin
        dp_kind = 1;
        dp_left = int'(nx.ws);
      end
      if (dp_kind == 1 && nx.wr) hwdata = nx.val << (8 * (int'(nx.addr) % nbytes(nx.tgt)));
      else hwdata = {$urandom, $urandom};
    end else if (dp_kind == 1) begin
      dp_left--;
    end else if (dp_kind == 2) begin
      dp_err1 = 1'b0;
    end
  endtask

  task automatic run_all();
    int cyc = 0;
    while ((q.size() > 0 || dp_kind != 0) && cyc < 60000) begin
      step();
      cyc++;
    end
    check_eq("drain_bound", 64'(cyc < 60000), 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_hreadyout32"}, 64'(hreadyout32), 64'd1);
    check_eq({tag, "_hresp32"}, 64'(hresp32), 64'd0);
    check_eq({tag, "_hrdata32"}, 64'(hrdata32), 64'd0);
    check_eq({tag, "_hreadyout64"}, 64'(hreadyout64), 64'd1);
    check_eq({tag, "_hresp64"}, 64'(hresp64), 64'd0);
    check_eq({tag, "_hrdata64"}, hrdata64, 64'd0);
  endtask

  initial begin
    logic [63:0] prior;
    hreset_n = 1'b0;
    drive(idle_xfer());
    hwdata  = '0;
    hready  = 1'b1;
    dp      = idle_xfer();
    dp_kind = 0;
    dp_left = 0;
    dp_err1 = 1'b0;
    repeat (3) @(posedge hclk);
    @(negedge hclk);
    check_reset_outputs("reset");
    @(posedge hclk);
    #1 hreset_n = 1'b1;

    // Fill both memories so every byte has a known value
    for (int a = 0; a < MemBytes / 4; a++) q.push_back(mk(0, 1, 32'(a * 4), 3'd2, 64'($urandom), 4'd0));
    for (int a = 0; a < MemBytes / 8; a++) q.push_back(mk(1, 1, 32'(a * 8), 3'd3, {$urandom, $urandom}, 4'd0));
    run_all();

    // Back-to-back write/read with forwarding, wait states, byte lanes
    q.push_back(mk(0, 1, 32'h10, 3'd2, 64'hDEAD_BEEF, 4'd0));
    q.push_back(mk_rd_chk(0, 32'h10, 3'd2, 4'd0, 64'h0000_0000_DEAD_BEEF));
    q.push_back(mk(0, 1, 32'h20, 3'd2, 64'h1234_5678, 4'd0));
    q.push_back(mk_rd_chk(0, 32'h20, 3'd2, 4'd3, 64'h0000_0000_1234_5678));
    q.push_back(mk(0, 1, 32'h40, 3'd0, 64'h11, 4'd0));
    q.push_back(mk(0, 1, 32'h41, 3'd0, 64'h22, 4'd0));
    q.push_back(mk(0, 1, 32'h42, 3'd0, 64'h33, 4'd0));
    q.push_back(mk(0, 1, 32'h43, 3'd0, 64'h44, 4'd0));
    q.push_back(mk(0, 1, 32'h42, 3'd1, 64'hAABB, 4'd0));
    q.push_back(mk_rd_chk(0, 32'h40, 3'd2, 4'd0, 64'h0000_0000_AABB_2211));
    q.push_back(mk(1, 1, 32'h8, 3'd3, 64'h0123_4567_89AB_CDEF, 4'd0));
    q.push_back(mk_rd_chk(1, 32'hB, 3'd0, 4'd0, 64'h0123_4567_89AB_CDEF));
    run_all();

    // Error responses; memory must stay untouched
    prior = model_word(0, 32'h0);
    q.push_back(mk(0, 0, 32'h1000, 3'd2, 64'd0, 4'd0));
    q.push_back(mk(0, 1, 32'h01, 3'd1, 64'hFFFF_FFFF, 4'd2));
    q.push_back(mk(1, 0, 32'h0, 3'b100, 64'd0, 4'd0));
    q.push_back(mk(0, 0, 32'h0, 3'd3, 64'd0, 4'd0));
    q.push_back(mk_rd_chk(0, 32'h0, 3'd2, 4'd0, prior));
    run_all();

    for (int i = 0; i < 600; i++) q.push_back(rand_xfer());
    run_all();

    // Reset in the middle of a write's wait states
    prior = model_word(0, 32'h30);
    q.push_back(mk(0, 1, 32'h30, 3'd2, 64'hCAFE_F00D, 4'd5));
    step();
    step();
    step();
    hreset_n = 1'b0;
    drive(idle_xfer());
    hready = 1'b1;
    #1;
    check_reset_outputs("midwait_reset");
    dp      = idle_xfer();
    dp_kind = 0;
    @(posedge hclk);
    @(posedge hclk);
    #1 hreset_n = 1'b1;
    q.push_back(mk_rd_chk(0, 32'h30, 3'd2, 4'd0, prior));
    run_all();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
